// File: rtl/fpu_arbiter_pkg.sv
// Shared FPU definitions: widths, command and rounding encodings,
// flag-bundle bit order, and the tag record used by the arbiter.
package fpu_arbiter_pkg;

  localparam int C_OP    = 32;
  localparam int C_CMD   = 4;
  localparam int C_RM    = 3;
  localparam int C_FLAGS = 6;
  localparam int C_ID_W  = 3;

  localparam logic [C_CMD-1:0] C_FPU_ADD_CMD  = 4'h0;
  localparam logic [C_CMD-1:0] C_FPU_SUB_CMD  = 4'h1;
  localparam logic [C_CMD-1:0] C_FPU_MUL_CMD  = 4'h2;
  localparam logic [C_CMD-1:0] C_FPU_DIV_CMD  = 4'h3;
  localparam logic [C_CMD-1:0] C_FPU_I2F_CMD  = 4'h4;
  localparam logic [C_CMD-1:0] C_FPU_F2I_CMD  = 4'h5;
  localparam logic [C_CMD-1:0] C_FPU_SQRT_CMD = 4'h6;
  localparam logic [C_CMD-1:0] C_FPU_NOP_CMD  = 4'h7;

  localparam logic [C_RM-1:0] C_RM_NEAREST  = 3'h0;
  localparam logic [C_RM-1:0] C_RM_TRUNC    = 3'h1;
  localparam logic [C_RM-1:0] C_RM_PLUSINF  = 3'h3;
  localparam logic [C_RM-1:0] C_RM_MINUSINF = 3'h2;

  // Flag bundle is {OF, UF, Zero, IX, IV, Inf}
  localparam int C_FLAG_OF   = 5;
  localparam int C_FLAG_UF   = 4;
  localparam int C_FLAG_ZERO = 3;
  localparam int C_FLAG_IX   = 2;
  localparam int C_FLAG_IV   = 1;
  localparam int C_FLAG_INF  = 0;

  typedef struct packed {
    logic              vld;
    logic [C_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fpu_arbiter_rr.sv
// Round-robin picker: rotating pointer and a one-hot grant
// for the first request at or after the pointer.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         Clk_CI,
  input  logic         Rst_RBI,
  input  logic [N-1:0] Req,
  output logic [N-1:0] Gnt,
  input  logic         Enable
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win;
  logic [N-1:0]  pick;
  logic          found;

  function automatic logic [PW-1:0] rot(
    input logic [PW-1:0] p,
    input int            k
  );
    int s;
    s = (int'(p) + k) % N;
    return PW'(s);
  endfunction

  always_comb begin
    pick  = '0;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && Req[rot(ptr_q, k)]) begin
        found = 1'b1;
        win   = rot(ptr_q, k);
        pick[rot(ptr_q, k)] = 1'b1;
      end
    end
  end

  assign Gnt = Enable ? pick : '0;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      ptr_q <= '0;
    end else if (Enable && found) begin
      ptr_q <= (int'(win) == N - 1) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// Shares one pipelined FPU among several requesters; a tag pipe
// routes each result back to its issuer after a fixed latency.
module fpu_arbiter
  import fpu_arbiter_pkg::*;
#(
  parameter int C_NUM_REQ = 4,
  parameter int C_LAT     = 3
) (
  input  logic                         Clk_CI,
  input  logic                         Rst_RBI,
  input  logic [C_NUM_REQ-1:0]         Req_SI,
  input  logic [C_NUM_REQ*C_OP-1:0]    Operand_a_DI,
  input  logic [C_NUM_REQ*C_OP-1:0]    Operand_b_DI,
  input  logic [C_NUM_REQ*C_CMD-1:0]   OP_SI,
  input  logic [C_NUM_REQ*C_RM-1:0]    RM_SI,
  input  logic                         Stall_SI,
  output logic [C_NUM_REQ-1:0]         Gnt_SO,
  output logic [C_OP-1:0]              FpuOperand_a_DO,
  output logic [C_OP-1:0]              FpuOperand_b_DO,
  output logic [C_CMD-1:0]             FpuOP_SO,
  output logic [C_RM-1:0]              FpuRM_SO,
  output logic                         FpuEnable_SO,
  output logic                         FpuStall_SO,
  input  logic [C_OP-1:0]              FpuResult_DI,
  input  logic [C_FLAGS-1:0]           FpuFlags_DI,
  output logic [C_OP-1:0]              Result_DO,
  output logic [C_FLAGS-1:0]           Flags_DO,
  output logic [C_NUM_REQ-1:0]         Valid_SO,
  output logic                         Busy_SO
);

  logic [C_NUM_REQ-1:0] gnt;
  logic [C_ID_W-1:0]    win;
  logic                 any;
  logic                 arb_en;
  tag_t                 tag_q [C_LAT];

  // Reset also blocks grants so nothing issues while held in reset
  assign arb_en = ~Stall_SI & Rst_RBI;

  rr_arbiter #(
    .N(C_NUM_REQ)
  ) u_rr (
    .Clk_CI (Clk_CI),
    .Rst_RBI(Rst_RBI),
    .Req    (Req_SI),
    .Gnt    (gnt),
    .Enable (arb_en)
  );

  assign Gnt_SO       = gnt;
  assign any          = |gnt;
  assign FpuEnable_SO = Rst_RBI;
  assign FpuStall_SO  = Stall_SI;
  assign Result_DO    = FpuResult_DI;
  assign Flags_DO     = FpuFlags_DI;

  always_comb begin
    win             = '0;
    FpuOperand_a_DO = '0;
    FpuOperand_b_DO = '0;
    FpuOP_SO        = C_FPU_NOP_CMD;
    FpuRM_SO        = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (gnt[i]) begin
        win             = C_ID_W'(i);
        FpuOperand_a_DO = Operand_a_DI[i*C_OP +: C_OP];
        FpuOperand_b_DO = Operand_b_DI[i*C_OP +: C_OP];
        FpuOP_SO        = OP_SI[i*C_CMD +: C_CMD];
        FpuRM_SO        = RM_SI[i*C_RM +: C_RM];
      end
    end
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < C_LAT; i++) begin
        tag_q[i] <= '0;
      end
    end else if (!Stall_SI) begin
      tag_q[0] <= '{vld: any, id: win};
      for (int i = 1; i < C_LAT; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  always_comb begin
    Valid_SO = '0;
    Busy_SO  = 1'b0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      Valid_SO[i] = tag_q[C_LAT-1].vld && !Stall_SI &&
                    (tag_q[C_LAT-1].id == C_ID_W'(i));
    end
    for (int i = 0; i < C_LAT; i++) begin
      Busy_SO = Busy_SO | tag_q[i].vld;
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Randomized bench for fpu_arbiter against a queue-based model
// of round-robin issue and fixed-latency result return.
module tb_fpu_arbiter;
  import fpu_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int LAT = 3;

  logic                 Clk_CI = 1'b0;
  logic                 Rst_RBI;
  logic [N-1:0]         Req_SI;
  logic [N*C_OP-1:0]    Operand_a_DI;
  logic [N*C_OP-1:0]    Operand_b_DI;
  logic [N*C_CMD-1:0]   OP_SI;
  logic [N*C_RM-1:0]    RM_SI;
  logic                 Stall_SI;
  logic [N-1:0]         Gnt_SO;
  logic [C_OP-1:0]      FpuOperand_a_DO;
  logic [C_OP-1:0]      FpuOperand_b_DO;
  logic [C_CMD-1:0]     FpuOP_SO;
  logic [C_RM-1:0]      FpuRM_SO;
  logic                 FpuEnable_SO;
  logic                 FpuStall_SO;
  logic [C_OP-1:0]      FpuResult_DI;
  logic [C_FLAGS-1:0]   FpuFlags_DI;
  logic [C_OP-1:0]      Result_DO;
  logic [C_FLAGS-1:0]   Flags_DO;
  logic [N-1:0]         Valid_SO;
  logic                 Busy_SO;

  fpu_arbiter #(
    .C_NUM_REQ(N),
    .C_LAT    (LAT)
  ) dut (
    .Clk_CI         (Clk_CI),
    .Rst_RBI        (Rst_RBI),
    .Req_SI         (Req_SI),
    .Operand_a_DI   (Operand_a_DI),
    .Operand_b_DI   (Operand_b_DI),
    .OP_SI          (OP_SI),
    .RM_SI          (RM_SI),
    .Stall_SI       (Stall_SI),
    .Gnt_SO         (Gnt_SO),
    .FpuOperand_a_DO(FpuOperand_a_DO),
    .FpuOperand_b_DO(FpuOperand_b_DO),
    .FpuOP_SO       (FpuOP_SO),
    .FpuRM_SO       (FpuRM_SO),
    .FpuEnable_SO   (FpuEnable_SO),
    .FpuStall_SO    (FpuStall_SO),
    .FpuResult_DI   (FpuResult_DI),
    .FpuFlags_DI    (FpuFlags_DI),
    .Result_DO      (Result_DO),
    .Flags_DO       (Flags_DO),
    .Valid_SO       (Valid_SO),
    .Busy_SO        (Busy_SO)
  );

  always #5 Clk_CI = ~Clk_CI;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int id;
    int g;
  } ent_t;

  ent_t q[$];
  int   mptr = 0;
  int   u    = 0;

  logic [C_OP-1:0]    opa [N];
  logic [C_OP-1:0]    opb [N];
  logic [C_CMD-1:0]   opc [N];
  logic [C_RM-1:0]    orm [N];
  bit                 keep_ops = 0;
  bit                 fix_res  = 0;
  logic [C_OP-1:0]    fres;
  logic [C_FLAGS-1:0] ffl;

  logic [N-1:0]       obs_gnt;
  logic [N-1:0]       obs_vld;
  logic               obs_busy;
  logic [C_OP-1:0]    obs_res;
  logic [C_FLAGS-1:0] obs_flg;
  logic [C_CMD-1:0]   obs_op;
  logic [C_OP-1:0]    obs_a;

  task automatic cycle(input logic [N-1:0] req, input logic stall);
    int           w;
    int           idx;
    logic [N-1:0] eg;
    logic [N-1:0] ev;
    bit           ret;
    Req_SI   = req;
    Stall_SI = stall;
    for (int i = 0; i < N; i++) begin
      if (!keep_ops) begin
        opa[i] = $urandom;
        opb[i] = $urandom;
        opc[i] = C_CMD'($urandom_range(0, 7));
        orm[i] = C_RM'($urandom_range(0, 3));
      end
      Operand_a_DI[i*C_OP +: C_OP]   = opa[i];
      Operand_b_DI[i*C_OP +: C_OP]   = opb[i];
      OP_SI[i*C_CMD +: C_CMD]        = opc[i];
      RM_SI[i*C_RM +: C_RM]          = orm[i];
    end
    FpuResult_DI = fix_res ? fres : C_OP'($urandom);
    FpuFlags_DI  = fix_res ? ffl : C_FLAGS'($urandom);
    #4;
    if (!Rst_RBI) begin
      q.delete();
      mptr = 0;
    end
    w = -1;
    if (Rst_RBI && !stall) begin
      for (int k = 0; k < N; k++) begin
        idx = (mptr + k) % N;
        if (w < 0 && req[idx]) w = idx;
      end
    end
    eg  = '0;
    if (w >= 0) eg[w] = 1'b1;
    ev  = '0;
    ret = Rst_RBI && !stall && q.size() > 0 && (q[0].g + LAT == u);
    if (ret) ev[q[0].id] = 1'b1;
    obs_gnt  = Gnt_SO;
    obs_vld  = Valid_SO;
    obs_busy = Busy_SO;
    obs_res  = Result_DO;
    obs_flg  = Flags_DO;
    obs_op   = FpuOP_SO;
    obs_a    = FpuOperand_a_DO;
    chk("gnt", Gnt_SO, eg);
    chk("valid", Valid_SO, ev);
    chk("busy", Busy_SO, Rst_RBI && q.size() > 0);
    chk("result", Result_DO, FpuResult_DI);
    chk("flags", Flags_DO, FpuFlags_DI);
    chk("opa", FpuOperand_a_DO, (w >= 0) ? opa[w] : '0);
    chk("opb", FpuOperand_b_DO, (w >= 0) ? opb[w] : '0);
    chk("cmd", FpuOP_SO, (w >= 0) ? opc[w] : C_FPU_NOP_CMD);
    chk("rm", FpuRM_SO, (w >= 0) ? orm[w] : '0);
    chk("fstall", FpuStall_SO, stall);
    chk("fen", FpuEnable_SO, Rst_RBI);
    @(posedge Clk_CI);
    if (Rst_RBI && !stall) begin
      if (ret) void'(q.pop_front());
      if (w >= 0) begin
        q.push_back('{id: w, g: u});
        mptr = (w + 1) % N;
      end
      u++;
    end
    #1;
  endtask

  initial begin
    Rst_RBI      = 1'b0;
    Req_SI       = '0;
    Stall_SI     = 1'b0;
    Operand_a_DI = '0;
    Operand_b_DI = '0;
    OP_SI        = '0;
    RM_SI        = '0;
    FpuResult_DI = '0;
    FpuFlags_DI  = '0;
    fres         = '0;
    ffl          = '0;
    #1;
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    Rst_RBI = 1'b1;
    cycle(4'b0000, 1'b0);
    chk("idle_cmd", obs_op, 4'h7);
    chk("idle_opa", obs_a, 32'h0);

    // reset mid-stream
    cycle(4'b0001, 1'b0);
    chk("mid_gnt", obs_gnt, 4'b0001);
    Rst_RBI = 1'b0;
    cycle(4'b0001, 1'b0);
    chk("rst_gnt0", obs_gnt, 4'b0000);
    cycle(4'b0001, 1'b0);
    chk("rst_gnt1", obs_gnt, 4'b0000);
    Rst_RBI = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0000, 1'b0);
      chk("rst_novalid", obs_vld, 4'b0000);
    end

    // round-robin from ptr=0
    for (int k = 0; k < 8; k++) begin
      cycle(4'b1111, 1'b0);
      if (k < 5) chk($sformatf("rr_gnt%0d", k), obs_gnt, 4'b0001 << (k % 4));
      if (k >= 3 && k < 7)
        chk($sformatf("rr_vld%0d", k), obs_vld, 4'b0001 << (k - 3));
    end
    for (int k = 0; k < 4; k++) cycle(4'b0000, 1'b0);
    chk("drain_busy", obs_busy, 1'b0);

    // result routing for requester 2
    keep_ops = 1;
    opa[2] = 32'h3F80_0000;
    opb[2] = 32'h4000_0000;
    opc[2] = C_FPU_ADD_CMD;
    orm[2] = C_RM_NEAREST;
    cycle(4'b0100, 1'b0);
    chk("route_gnt", obs_gnt, 4'b0100);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    fix_res = 1;
    fres    = 32'h4040_0000;
    ffl     = '0;
    cycle(4'b0000, 1'b0);
    chk("route_vld", obs_vld, 4'b0100);
    chk("route_res", obs_res, 32'h4040_0000);
    chk("route_flg", obs_flg, 6'h0);
    fix_res  = 0;
    keep_ops = 0;

    // stall with two in flight: ptr=3 after the routing grant
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b1);
    chk("stall_gnt0", obs_gnt, 4'b0000);
    chk("stall_vld0", obs_vld, 4'b0000);
    cycle(4'b1111, 1'b1);
    chk("stall_gnt1", obs_gnt, 4'b0000);
    cycle(4'b0000, 1'b0);
    chk("stall_early", obs_vld, 4'b0000);
    cycle(4'b0000, 1'b0);
    chk("stall_ret3", obs_vld, 4'b1000);
    cycle(4'b0000, 1'b0);
    chk("stall_ret0", obs_vld, 4'b0001);
    cycle(4'b0000, 1'b0);

    // fairness wrap with ptr=1
    cycle(4'b1001, 1'b0);
    chk("wrap_first", obs_gnt, 4'b1000);
    cycle(4'b1001, 1'b0);
    chk("wrap_second", obs_gnt, 4'b0001);
    for (int k = 0; k < 3; k++) cycle(4'b0000, 1'b0);
    chk("busy_last", obs_busy, 1'b1);
    cycle(4'b0000, 1'b0);
    chk("busy_fall", obs_busy, 1'b0);

    // randomized traffic with stalls and occasional resets
    for (int k = 0; k < 400; k++) begin
      Rst_RBI = ($urandom_range(0, 99) != 0);
      cycle(N'($urandom), ($urandom_range(0, 4) == 0));
    end
    Rst_RBI = 1'b1;
    for (int k = 0; k < 6; k++) cycle(4'b0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shares one pipelined `fpu` instance between `C_NUM_REQ` requesters (core lanes or accelerator ports).
- Picks one requester per cycle by round-robin and drives the selected operands and command into the FPU.
- Tracks each issued operation in a tag pipeline and returns the FPU result and flags to the originating requester exactly `C_LAT` cycles later.
- Sits between the requesters and `fpu`; the FPU is unmodified.

## Interface
- `C_NUM_REQ`, 4: number of requesters, 2..8
- `C_LAT`, 3: cycles from the grant edge to the FPU result being valid (input register plus core pipeline), ≥1
- `C_OP`, 32: operand/result width
- `C_CMD`, 4: command width
- `C_RM`, 3: rounding-mode width
- `C_FLAGS`, 6: flag bundle {OF, UF, Zero, IX, IV, Inf}
- `Clk_CI`  in  1  clock; single clock domain
- `Rst_RBI`  in  1  reset, asynchronous, active-low
- `Req_SI`  in  C_NUM_REQ  per-requester request; held until granted
- `Operand_a_DI`  in  C_NUM_REQ*C_OP  packed operand A, requester i at [i*C_OP +: C_OP]
- `Operand_b_DI`  in  C_NUM_REQ*C_OP  packed operand B
- `OP_SI`  in  C_NUM_REQ*C_CMD  packed command
- `RM_SI`  in  C_NUM_REQ*C_RM  packed rounding mode
- `Stall_SI`  in  1  global pipeline freeze
- `Gnt_SO`  out  C_NUM_REQ  one-hot grant, combinational, same cycle as request
- `FpuOperand_a_DO`, `FpuOperand_b_DO`  out  C_OP  to FPU operands
- `FpuOP_SO`  out  C_CMD  to FPU command
- `FpuRM_SO`  out  C_RM  to FPU rounding mode
- `FpuEnable_SO`  out  1  to FPU enable
- `FpuStall_SO`  out  1  to FPU stall
- `FpuResult_DI`  in  C_OP  FPU result
- `FpuFlags_DI`  in  C_FLAGS  FPU flags
- `Result_DO`  out  C_OP  broadcast result
- `Flags_DO`  out  C_FLAGS  broadcast flags
- `Valid_SO`  out  C_NUM_REQ  one-hot result-valid for the owning requester
- `Busy_SO`  out  1  any operation in flight

## Operation
- **Arbitration**
  - Round-robin pointer `ptr` (log2 C_NUM_REQ bits). The winner is the first set `Req_SI` bit at or after `ptr`, wrapping.
  - On a grant, `ptr` <= winner+1 mod C_NUM_REQ. With no grant, `ptr` holds.
  - At most one `Gnt_SO` bit is set. It is set only when `Req_SI` has that bit set and `Stall_SI`=0.
- **Issue mux**
  - `FpuOperand_*`, `FpuOP_SO` and `FpuRM_SO` carry the winner's fields.
  - With no grant they drive zeros and `FpuOP_SO`=C_FPU_NOP_CMD (4'h7).
  - `FpuEnable_SO`=1 whenever Rst_RBI is deasserted.
  - `FpuStall_SO`=`Stall_SI`.
- **Tag pipeline**
  - `C_LAT` stages, each {valid, id}. Stage 0 loads {grant, winner id} on each unstalled edge; the pipe shifts on every edge with `Stall_SI`=0.
  - `Valid_SO`[id] is set when the last stage is valid and `Stall_SI`=0.
  - `Result_DO` and `Flags_DO` pass `FpuResult_DI` and `FpuFlags_DI` through combinationally.
- Requesters must accept results unconditionally; there is no result back-pressure.
- Results return in issue order. A requester may have multiple operations in flight.
- `Busy_SO` = OR of all stage valid bits.
- NOP commands from a requester are granted and returned like any other command.

## Timing
- **Reset values:** `ptr`=0, all tag stages invalid, `Gnt_SO`=0, `Valid_SO`=0, `Busy_SO`=0, FPU outputs as the idle mux.
- **Latency:** grant in cycle t gives `Valid_SO` in cycle t+C_LAT, counting unstalled cycles only.
- **Throughput:** one grant per unstalled cycle.
- **`Stall_SI`=1:**
  - no grants; `ptr` and the tag pipe hold; `Valid_SO` is masked to 0.
  - The held last-stage entry is presented on the first unstalled cycle.
- **Request dropped before grant:** legal and ignored; no state change.
- **Simultaneous grant and result return in the same cycle:** both occur; no interaction.
- **Reset mid-operation:** in-flight tags are discarded and no `Valid_SO` is produced for them. Requesters re-issue.
- **Single requester continuously asserting:** granted every unstalled cycle.

## Structure
- Shared include `fpu_defines`:
  - C_OP, C_CMD, C_RM, C_FLAGS
  - all C_FPU_*_CMD encodings, including C_FPU_NOP_CMD
  - C_RM_* encodings
  - the flag-bundle bit order
- Sub-module `rr_arbiter` (parameter N, ports Clk_CI, Rst_RBI, Req, Gnt, Enable) contains the pointer and the one-hot pick.
- The top level contains the operand mux, the tag pipeline and the valid decode.

## Test plan
- **Reset mid-stream:** Req_SI=4'b0001, reset after 1 grant -> Gnt_SO stays 0 during reset; no Valid_SO afterwards; ptr=0 after release.
- **Round-robin:** all four requesters request continuously, C_LAT=3 -> grants 0,1,2,3,0 in consecutive cycles; Valid_SO one-hot 0001,0010,0100,1000 starting 3 cycles after the first grant.
- **Result routing:** requester 2 issues ADD 0x3F800000 + 0x40000000 -> Valid_SO=4'b0100 at t+3 with Result_DO=0x40400000, Flags_DO=0.
- **Stall:** Stall_SI high for 2 cycles while 2 operations are in flight -> no grants, Valid_SO=0 while stalled; returns resume with total delay C_LAT+2; order preserved.
- **Fairness wrap:** Req_SI=4'b1001 with ptr=1 -> requester 3 granted first, then requester 0.
- **Idle:** Req_SI=0 -> FpuOP_SO=4'h7, operands 0, Busy_SO falls to 0 C_LAT cycles after the last grant.
